// File: rtl/dcache_pkg.sv
// Shared geometry, FSM state encoding, tag-entry layout and address helpers
// for the direct-mapped L1 data cache controller.
package dcache_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned TAG_W   = 22;
  localparam int unsigned IDX_W   = 5;
  localparam int unsigned SEL_W   = 3;
  localparam int unsigned OFF_W   = 5;
  localparam int unsigned BYTE_W  = 2;
  localparam int unsigned LINE_W  = 256;
  localparam int unsigned TENT_W  = TAG_W + 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MISS,
    S_WRITEBACK,
    S_ALLOCATE,
    S_REFILL
  } state_e;

  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic [TAG_W-1:0] tag;
  } tag_entry_t;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] addr);
    return addr[OFF_W +: IDX_W];
  endfunction

  function automatic logic [SEL_W-1:0] addr_sel(input logic [ADDR_W-1:0] addr);
    return addr[BYTE_W +: SEL_W];
  endfunction

  // Line-aligned memory address rebuilt from a tag and an index.
  function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] tag,
                                                   input logic [IDX_W-1:0] idx);
    return {tag, idx, {OFF_W{1'b0}}};
  endfunction

endpackage

// File: rtl/dcache_word_merge.sv
// Replaces one 32-bit word of a 256-bit cache line; purely combinational.
module dcache_word_merge
  import dcache_pkg::*;
(
  input  logic [LINE_W-1:0] line,
  input  logic [WORD_W-1:0] word,
  input  logic [SEL_W-1:0]  sel,
  output logic [LINE_W-1:0] merged
);

  logic [7:0] base;

  assign base = {sel, 5'd0};

  always_comb begin
    merged = line;
    merged[base +: WORD_W] = word;
  end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back / write-allocate L1 data cache controller:
// hit resolution, store merge, write-back and refill sequencing.
module dcache_controller
  import dcache_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                p1_req_i,
  input  logic                p1_write_i,
  input  logic [ADDR_W-1:0]   p1_addr_i,
  input  logic [WORD_W-1:0]   p1_data_i,
  output logic [WORD_W-1:0]   p1_data_o,
  output logic                p1_stall_o,
  output logic                sram_enable_o,
  output logic                sram_write_o,
  output logic [IDX_W-1:0]    sram_addr_o,
  output logic [TENT_W-1:0]   tag_data_o,
  input  logic [TENT_W-1:0]   tag_data_i,
  output logic [LINE_W-1:0]   line_data_o,
  input  logic [LINE_W-1:0]   line_data_i,
  output logic                mem_enable_o,
  output logic                mem_write_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [LINE_W-1:0]   mem_data_o,
  input  logic [LINE_W-1:0]   mem_data_i,
  input  logic                mem_ack_i
);

  state_e            state_q;
  state_e            state_d;
  tag_entry_t        tag_rd;
  tag_entry_t        tag_wr;
  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [SEL_W-1:0]  req_sel;
  logic [7:0]        word_base;
  logic              hit;
  logic              victim_dirty;
  logic [LINE_W-1:0] merged_line;
  logic [LINE_W-1:0] refill_q;
  logic              unused_addr_bits;

  assign tag_rd           = tag_entry_t'(tag_data_i);
  assign req_tag          = addr_tag(p1_addr_i);
  assign req_idx          = addr_idx(p1_addr_i);
  assign req_sel          = addr_sel(p1_addr_i);
  assign word_base        = {req_sel, 5'd0};
  assign unused_addr_bits = ^p1_addr_i[BYTE_W-1:0];

  assign hit          = p1_req_i & tag_rd.valid & (tag_rd.tag == req_tag);
  assign victim_dirty = tag_rd.valid & tag_rd.dirty;
  assign p1_stall_o   = (state_q != S_IDLE) | (p1_req_i & ~hit);
  assign tag_data_o   = tag_wr;

  dcache_word_merge u_word_merge (
    .line   (line_data_i),
    .word   (p1_data_i),
    .sel    (req_sel),
    .merged (merged_line)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:      if (p1_req_i && !hit) state_d = S_MISS;
      S_MISS:      state_d = victim_dirty ? S_WRITEBACK : S_ALLOCATE;
      S_WRITEBACK: if (mem_ack_i) state_d = S_ALLOCATE;
      S_ALLOCATE:  if (mem_ack_i) state_d = S_REFILL;
      S_REFILL:    state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // SRAM-side and CPU read-data outputs; everything idles at zero.
  always_comb begin
    sram_enable_o = 1'b0;
    sram_write_o  = 1'b0;
    sram_addr_o   = '0;
    tag_wr        = '0;
    line_data_o   = '0;
    p1_data_o     = '0;
    unique case (state_q)
      S_IDLE: begin
        sram_enable_o = p1_req_i;
        sram_addr_o   = p1_req_i ? req_idx : '0;
        if (hit) begin
          if (p1_write_i) begin
            sram_write_o = 1'b1;
            line_data_o  = merged_line;
            tag_wr       = '{valid: 1'b1, dirty: 1'b1, tag: req_tag};
          end else begin
            p1_data_o = line_data_i[word_base +: WORD_W];
          end
        end
      end
      S_MISS: begin
        sram_enable_o = 1'b1;
        sram_addr_o   = req_idx;
      end
      S_WRITEBACK, S_ALLOCATE: begin
        sram_addr_o = req_idx;
      end
      S_REFILL: begin
        sram_enable_o = 1'b1;
        sram_write_o  = 1'b1;
        sram_addr_o   = req_idx;
        line_data_o   = refill_q;
        tag_wr        = '{valid: 1'b1, dirty: 1'b0, tag: req_tag};
      end
      default: ;
    endcase
  end

  // Memory request registers and refill buffer; enable stays high from the
  // write-back into the fetch so the memory sees one continuous request.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
      refill_q     <= '0;
    end else begin
      unique case (state_q)
        S_MISS: begin
          mem_enable_o <= 1'b1;
          if (victim_dirty) begin
            mem_write_o <= 1'b1;
            mem_addr_o  <= line_addr(tag_rd.tag, req_idx);
            mem_data_o  <= line_data_i;
          end else begin
            mem_write_o <= 1'b0;
            mem_addr_o  <= line_addr(req_tag, req_idx);
          end
        end
        S_WRITEBACK: begin
          if (mem_ack_i) begin
            mem_write_o <= 1'b0;
            mem_addr_o  <= line_addr(req_tag, req_idx);
          end
        end
        S_ALLOCATE: begin
          if (mem_ack_i) begin
            mem_enable_o <= 1'b0;
            refill_q     <= mem_data_i;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller with behavioural tag/data SRAMs.
module tb_dcache_controller;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         p1_req_i;
  logic         p1_write_i;
  logic [31:0]  p1_addr_i;
  logic [31:0]  p1_data_i;
  logic [31:0]  p1_data_o;
  logic         p1_stall_o;
  logic         sram_enable_o;
  logic         sram_write_o;
  logic [4:0]   sram_addr_o;
  logic [23:0]  tag_data_o;
  logic [23:0]  tag_data_i;
  logic [255:0] line_data_o;
  logic [255:0] line_data_i;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;

  logic [23:0]  tag_mem  [32] = '{default: '0};
  logic [255:0] data_mem [32] = '{default: '0};

  int vectors = 0;
  int miscompares = 0;

  dcache_controller dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .p1_req_i      (p1_req_i),
    .p1_write_i    (p1_write_i),
    .p1_addr_i     (p1_addr_i),
    .p1_data_i     (p1_data_i),
    .p1_data_o     (p1_data_o),
    .p1_stall_o    (p1_stall_o),
    .sram_enable_o (sram_enable_o),
    .sram_write_o  (sram_write_o),
    .sram_addr_o   (sram_addr_o),
    .tag_data_o    (tag_data_o),
    .tag_data_i    (tag_data_i),
    .line_data_o   (line_data_o),
    .line_data_i   (line_data_i),
    .mem_enable_o  (mem_enable_o),
    .mem_write_o   (mem_write_o),
    .mem_addr_o    (mem_addr_o),
    .mem_data_o    (mem_data_o),
    .mem_data_i    (mem_data_i),
    .mem_ack_i     (mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  assign tag_data_i  = tag_mem[sram_addr_o];
  assign line_data_i = data_mem[sram_addr_o];

  always @(negedge clk_i) begin
    if (sram_enable_o && sram_write_o) begin
      tag_mem[sram_addr_o]  <= tag_data_o;
      data_mem[sram_addr_o] <= line_data_o;
    end
  end

  function automatic logic [255:0] make_line(input logic [31:0] base);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + 32'(i);
    return l;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  logic [255:0] l1, l2, l3, l4, l1m, l3m;

  initial begin
    l1  = make_line(32'h1000_0000);
    l2  = make_line(32'h2000_0000);
    l3  = make_line(32'h3000_0000);
    l4  = make_line(32'h4000_0000);
    l1m = l1; l1m[32 +: 32] = 32'hDEAD_BEEF;
    l3m = l3; l3m[64 +: 32] = 32'hCAFE_F00D;

    rst_i = 1'b0; p1_req_i = 1'b0; p1_write_i = 1'b0;
    p1_addr_i = '0; p1_data_i = '0; mem_data_i = '0; mem_ack_i = 1'b0;
    #2;
    chk("rst_stall",   256'(p1_stall_o), 256'(0));
    chk("rst_mem_en",  256'(mem_enable_o), 256'(0));
    chk("rst_mem_adr", 256'(mem_addr_o), 256'(0));
    chk("rst_sram_en", 256'(sram_enable_o), 256'(0));
    chk("rst_p1_data", 256'(p1_data_o), 256'(0));
    #10 rst_i = 1'b1;
    tick();

    // Clean load miss at 0x40, ack in third ALLOCATE cycle
    p1_req_i = 1'b1; p1_write_i = 1'b0; p1_addr_i = 32'h40;
    #1;
    chk("ld40_idle_stall", 256'(p1_stall_o), 256'(1));
    chk("ld40_idle_sram_wr", 256'(sram_write_o), 256'(0));
    tick();
    chk("ld40_miss_stall", 256'(p1_stall_o), 256'(1));
    chk("ld40_miss_mem_en", 256'(mem_enable_o), 256'(0));
    tick();
    chk("ld40_alloc_en", 256'(mem_enable_o), 256'(1));
    chk("ld40_alloc_wr", 256'(mem_write_o), 256'(0));
    chk("ld40_alloc_adr", 256'(mem_addr_o), 256'(32'h40));
    tick();
    tick();
    mem_ack_i = 1'b1; mem_data_i = l1;
    tick();
    mem_ack_i = 1'b0;
    chk("ld40_refill_mem_en", 256'(mem_enable_o), 256'(0));
    chk("ld40_refill_stall", 256'(p1_stall_o), 256'(1));
    chk("ld40_refill_wr", 256'(sram_write_o), 256'(1));
    chk("ld40_refill_adr", 256'(sram_addr_o), 256'(2));
    chk("ld40_refill_tag", 256'(tag_data_o), 256'(24'h80_0000));
    chk("ld40_refill_line", line_data_o, l1);
    tick();
    chk("ld40_replay_stall", 256'(p1_stall_o), 256'(0));
    chk("ld40_replay_data", 256'(p1_data_o), 256'(32'h1000_0000));
    tick();

    // Store hit to 0x44
    p1_write_i = 1'b1; p1_addr_i = 32'h44; p1_data_i = 32'hDEAD_BEEF;
    #1;
    chk("st44_stall", 256'(p1_stall_o), 256'(0));
    chk("st44_sram_wr", 256'(sram_write_o), 256'(1));
    chk("st44_tag", 256'(tag_data_o), 256'(24'hC0_0000));
    chk("st44_line", line_data_o, l1m);
    chk("st44_p1_data", 256'(p1_data_o), 256'(0));
    tick();
    p1_write_i = 1'b0;
    #1;
    chk("ld44_stall", 256'(p1_stall_o), 256'(0));
    chk("ld44_data", 256'(p1_data_o), 256'(32'hDEAD_BEEF));
    chk("sram2_tag", 256'(tag_mem[2]), 256'(24'hC0_0000));
    tick();

    // Dirty miss at 0x440: write-back of 0x40 (ack in first cycle), then fetch
    p1_addr_i = 32'h440;
    #1;
    chk("ld440_stall", 256'(p1_stall_o), 256'(1));
    tick();
    tick();
    chk("wb_en", 256'(mem_enable_o), 256'(1));
    chk("wb_wr", 256'(mem_write_o), 256'(1));
    chk("wb_adr", 256'(mem_addr_o), 256'(32'h40));
    chk("wb_data", mem_data_o, l1m);
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    chk("wb2alloc_en", 256'(mem_enable_o), 256'(1));
    chk("wb2alloc_wr", 256'(mem_write_o), 256'(0));
    chk("wb2alloc_adr", 256'(mem_addr_o), 256'(32'h440));
    tick();
    mem_ack_i = 1'b1; mem_data_i = l2;
    tick();
    mem_ack_i = 1'b0;
    chk("ld440_refill_tag", 256'(tag_data_o), 256'(24'h80_0001));
    chk("ld440_refill_line", line_data_o, l2);
    tick();
    chk("ld440_replay_stall", 256'(p1_stall_o), 256'(0));
    chk("ld440_replay_data", 256'(p1_data_o), 256'(32'h2000_0000));
    tick();

    // Store miss to clean index 4
    p1_write_i = 1'b1; p1_addr_i = 32'h88; p1_data_i = 32'hCAFE_F00D;
    #1;
    chk("st88_stall", 256'(p1_stall_o), 256'(1));
    chk("st88_sram_wr", 256'(sram_write_o), 256'(0));
    tick();
    tick();
    chk("st88_alloc_wr", 256'(mem_write_o), 256'(0));
    chk("st88_alloc_adr", 256'(mem_addr_o), 256'(32'h80));
    mem_ack_i = 1'b1; mem_data_i = l3;
    tick();
    mem_ack_i = 1'b0;
    chk("st88_refill_tag", 256'(tag_data_o), 256'(24'h80_0000));
    tick();
    chk("st88_replay_stall", 256'(p1_stall_o), 256'(0));
    chk("st88_replay_wr", 256'(sram_write_o), 256'(1));
    chk("st88_replay_tag", 256'(tag_data_o), 256'(24'hC0_0000));
    chk("st88_replay_line", line_data_o, l3m);
    tick();
    chk("sram4_tag", 256'(tag_mem[4]), 256'(24'hC0_0000));

    // Reset during ALLOCATE, then the same load restarts
    p1_write_i = 1'b0; p1_addr_i = 32'h100;
    tick();
    tick();
    chk("rstmid_alloc_en", 256'(mem_enable_o), 256'(1));
    #1 rst_i = 1'b0;
    #1;
    chk("rstmid_mem_en", 256'(mem_enable_o), 256'(0));
    chk("rstmid_sram_wr", 256'(sram_write_o), 256'(0));
    chk("rstmid_sram_adr", 256'(sram_addr_o), 256'(8));
    #4 rst_i = 1'b1;
    tick();
    chk("restart_miss_en", 256'(mem_enable_o), 256'(0));
    chk("restart_stall", 256'(p1_stall_o), 256'(1));
    tick();
    chk("restart_alloc_en", 256'(mem_enable_o), 256'(1));
    chk("restart_alloc_adr", 256'(mem_addr_o), 256'(32'h100));
    mem_ack_i = 1'b1; mem_data_i = l4;
    tick();
    mem_ack_i = 1'b0;
    tick();
    chk("restart_replay_stall", 256'(p1_stall_o), 256'(0));
    chk("restart_replay_data", 256'(p1_data_o), 256'(32'h4000_0000));
    tick();

    // Stray acks while idle
    p1_req_i = 1'b0; mem_ack_i = 1'b1;
    #1;
    chk("stray_stall", 256'(p1_stall_o), 256'(0));
    chk("stray_sram_en", 256'(sram_enable_o), 256'(0));
    chk("stray_sram_wr", 256'(sram_write_o), 256'(0));
    tick();
    chk("stray_mem_en", 256'(mem_enable_o), 256'(0));
    p1_req_i = 1'b1; p1_addr_i = 32'h440;
    #1;
    chk("stray_hit_stall", 256'(p1_stall_o), 256'(0));
    chk("stray_hit_data", 256'(p1_data_o), 256'(32'h2000_0000));
    chk("stray_hit_sram_wr", 256'(sram_write_o), 256'(0));
    tick();
    mem_ack_i = 1'b0; p1_req_i = 1'b0;
    #1;
    chk("final_mem_en", 256'(mem_enable_o), 256'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
